// File: rtl/t_stream_buffer_pkg.sv
// rtl/t_stream_buffer_pkg.sv - shared constants and types for the target stream buffer
package t_stream_buffer_pkg;

  // Default geometry
  localparam int DEPTH_DEF    = 1024;
  localparam int ADDR_BIT_DEF = 10;
  localparam int VEF_BIT_DEF  = 16;

  // Base encoding of the target sequence
  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  // Buffer control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } tbuf_state_e;

endpackage

// File: rtl/tbuf_mem.sv
// rtl/tbuf_mem.sv - tuple storage: one synchronous write port, one asynchronous read port
module tbuf_mem
  import t_stream_buffer_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_BIT = ADDR_BIT_DEF,
  parameter int WIDTH    = 2 + 2 * VEF_BIT_DEF
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [ADDR_BIT-1:0] waddr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic [ADDR_BIT-1:0] raddr_i,
  output logic [WIDTH-1:0]    rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are not reset; the owner only exposes entries it has written
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/t_stream_buffer.sv
// rtl/t_stream_buffer.sv - circular buffer recirculating target tuples {t,v,f}; TBUF_ERR_CHECK_EN enables o_err
module t_stream_buffer
  import t_stream_buffer_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_BIT = ADDR_BIT_DEF,
  parameter int VEF_BIT  = VEF_BIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_load_start,
  input  logic                i_load_valid,
  input  logic [1:0]          i_load_t,
  input  logic                i_load_last,
  input  logic                i_rd,
  input  logic                i_wr,
  input  logic [1:0]          i_wr_t,
  input  logic [VEF_BIT-1:0]  i_wr_v,
  input  logic [VEF_BIT-1:0]  i_wr_f,
  output logic                o_valid,
  output logic [1:0]          o_t,
  output logic [VEF_BIT-1:0]  o_v,
  output logic [VEF_BIT-1:0]  o_f,
  output logic                o_t_last,
  output logic                o_ready,
  output logic [ADDR_BIT:0]   o_len,
  output logic                o_err
);

  localparam int                TW        = 2 + 2 * VEF_BIT;
  localparam logic [ADDR_BIT:0] DEPTH_CNT = (ADDR_BIT + 1)'(DEPTH);

  tbuf_state_e         state_q, state_d;
  logic [ADDR_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BIT:0]   count_q, count_d;
  logic [ADDR_BIT:0]   len_q, len_d;
  logic [ADDR_BIT:0]   len_m1;
  logic                in_run, in_load;
  logic                rd_ok, wr_ok, ld_ok;
  logic                mem_we;
  logic [TW-1:0]       mem_wdata, mem_rdata;

  // Ring pointers wrap at the loaded length, not at DEPTH
  function automatic logic [ADDR_BIT-1:0] adv(input logic [ADDR_BIT-1:0] p,
                                              input logic [ADDR_BIT:0]   last_idx);
    return ({1'b0, p} == last_idx) ? '0 : p + 1'b1;
  endfunction

  assign in_run  = (state_q == ST_RUN);
  assign in_load = (state_q == ST_LOAD);
  assign len_m1  = len_q - 1'b1;

  // A read needs a head tuple; a write needs room unless a read frees a slot this cycle
  assign rd_ok = in_run && i_rd && (count_q != '0);
  assign wr_ok = in_run && i_wr && ((count_q != len_q) || rd_ok);
  assign ld_ok = in_load && i_load_valid && (count_q != DEPTH_CNT);

  // Next-state logic for control, pointers, occupancy and length
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    len_d    = len_q;
    if (i_clear) begin
      state_d  = ST_IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      len_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_load_start) begin
            state_d  = ST_LOAD;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            len_d    = '0;
          end
        end
        ST_LOAD: begin
          if (ld_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
          // The buffer is full on entry to RUN, so the write pointer rejoins the read pointer at 0
          if (i_load_valid && i_load_last) begin
            state_d  = ST_RUN;
            len_d    = ld_ok ? count_q + 1'b1 : count_q;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
          end
        end
        ST_RUN: begin
          if (rd_ok) rd_ptr_d = adv(rd_ptr_q, len_m1);
          if (wr_ok) wr_ptr_d = adv(wr_ptr_q, len_m1);
          case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      len_q    <= len_d;
    end
  end

  assign mem_we    = !i_clear && (ld_ok || wr_ok);
  assign mem_wdata = in_run ? {i_wr_t, i_wr_v, i_wr_f} : {i_load_t, {(2 * VEF_BIT){1'b0}}};

  tbuf_mem #(
    .DEPTH    (DEPTH),
    .ADDR_BIT (ADDR_BIT),
    .WIDTH    (TW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (mem_wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Head data is forced to zero whenever no tuple is presented
  assign o_valid  = in_run && (count_q != '0);
  assign o_t      = o_valid ? mem_rdata[TW-1 -: 2] : '0;
  assign o_v      = o_valid ? mem_rdata[2*VEF_BIT-1 -: VEF_BIT] : '0;
  assign o_f      = o_valid ? mem_rdata[VEF_BIT-1:0] : '0;
  assign o_t_last = o_valid && ({1'b0, rd_ptr_q} == len_m1);
  assign o_ready  = in_run;
  assign o_len    = len_q;

`ifdef TBUF_ERR_CHECK_EN
  logic err_q;
  logic err_set;

  assign err_set = (i_rd && !rd_ok) || (i_wr && !wr_ok) || (in_load && i_load_valid && !ld_ok);

  // Sticky protocol error, cleared only by reset or clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (i_clear) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_t_stream_buffer.sv
// tb/tb_t_stream_buffer.sv - scoreboard bench for t_stream_buffer against a queue model
module tb_t_stream_buffer;
  import t_stream_buffer_pkg::*;

  localparam int DEPTH    = 16;
  localparam int ADDR_BIT = 4;
  localparam int VEF_BIT  = 16;
`ifdef TBUF_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_clear = 1'b0, i_load_start = 1'b0, i_load_valid = 1'b0, i_load_last = 1'b0;
  logic [1:0]         i_load_t = '0, i_wr_t = '0;
  logic               i_rd = 1'b0, i_wr = 1'b0;
  logic [VEF_BIT-1:0] i_wr_v = '0, i_wr_f = '0;
  logic               o_valid, o_t_last, o_ready, o_err;
  logic [1:0]         o_t;
  logic [VEF_BIT-1:0] o_v, o_f;
  logic [ADDR_BIT:0]  o_len;

  t_stream_buffer #(.DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT), .VEF_BIT(VEF_BIT)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_load_start(i_load_start),
    .i_load_valid(i_load_valid), .i_load_t(i_load_t), .i_load_last(i_load_last),
    .i_rd(i_rd), .i_wr(i_wr), .i_wr_t(i_wr_t), .i_wr_v(i_wr_v), .i_wr_f(i_wr_f),
    .o_valid(o_valid), .o_t(o_t), .o_v(o_v), .o_f(o_f), .o_t_last(o_t_last),
    .o_ready(o_ready), .o_len(o_len), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         t;
    logic [VEF_BIT-1:0] v;
    logic [VEF_BIT-1:0] f;
  } tup_t;

  typedef enum {M_IDLE, M_LOAD, M_RUN} mstate_e;

  typedef struct {
    logic valid, ready, last, err, chk0;
    logic [1:0] t;
    logic [VEF_BIT-1:0] v, f;
    logic [ADDR_BIT:0] len;
  } exp_t;

  // Reference: queue of live tuples in stream order, plus head column index
  tup_t    m_q[$];
  mstate_e m_st;
  int      m_len, m_head;
  bit      m_err;
  exp_t    exp_q[$];
  int      errors = 0, checks = 0;
  logic [1:0] acgt [4] = '{BASE_A, BASE_C, BASE_G, BASE_T};

  function automatic void m_reset();
    m_q.delete();
    m_st = M_IDLE; m_len = 0; m_head = 0; m_err = 1'b0;
  endfunction

  function automatic void push_exp(bit chk0);
    exp_t e;
    e.valid = (m_st == M_RUN) && (m_q.size() > 0);
    e.ready = (m_st == M_RUN);
    e.len   = m_len[ADDR_BIT:0];
    e.err   = ERR_EN && m_err;
    e.last  = e.valid && (m_head == m_len - 1);
    e.chk0  = chk0;
    e.t = '0; e.v = '0; e.f = '0;
    if (e.valid) begin
      e.t = m_q[0].t; e.v = m_q[0].v; e.f = m_q[0].f;
    end
    exp_q.push_back(e);
  endfunction

  function automatic void m_step(bit c, bit s, bit lv, logic [1:0] lt, bit ll, bit rd, bit wr, tup_t w);
    bit   rd_ok, wr_ok;
    tup_t n;
    if (c) begin
      m_reset();
      return;
    end
    case (m_st)
      M_IDLE: begin
        if (rd || wr) m_err = 1'b1;
        if (s) begin
          m_q.delete(); m_len = 0; m_head = 0; m_st = M_LOAD;
        end
      end
      M_LOAD: begin
        if (rd || wr) m_err = 1'b1;
        if (lv) begin
          if (m_q.size() < DEPTH) begin
            n.t = lt; n.v = '0; n.f = '0;
            m_q.push_back(n);
          end else m_err = 1'b1;
          if (ll) begin
            m_len = m_q.size(); m_head = 0; m_st = M_RUN;
          end
        end
      end
      default: begin
        rd_ok = rd && (m_q.size() > 0);
        wr_ok = wr && ((m_q.size() < m_len) || rd_ok);
        if (rd && !rd_ok) m_err = 1'b1;
        if (wr && !wr_ok) m_err = 1'b1;
        if (rd_ok) begin
          void'(m_q.pop_front());
          m_head = (m_head + 1) % m_len;
        end
        if (wr_ok) m_q.push_back(w);
      end
    endcase
  endfunction

  task automatic tick(bit c, bit s, bit lv, logic [1:0] lt, bit ll, bit rd, bit wr,
                      logic [1:0] wt, logic [VEF_BIT-1:0] wv, logic [VEF_BIT-1:0] wf);
    tup_t w;
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_clear = c; i_load_start = s; i_load_valid = lv; i_load_t = lt; i_load_last = ll;
    i_rd = rd; i_wr = wr; i_wr_t = wt; i_wr_v = wv; i_wr_f = wf;
    push_exp(1'b0);
    w.t = wt; w.v = wv; w.f = wf;
    m_step(c, s, lv, lt, ll, rd, wr, w);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 2'd0, 0, 0, 0, 2'd0, '0, '0);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    i_clear = 0; i_load_start = 0; i_load_valid = 0; i_load_last = 0; i_rd = 0; i_wr = 0;
    m_reset();
    push_exp(1'b1);
  endtask

  task automatic clear();
    tick(1, 0, 0, 2'd0, 0, 0, 0, 2'd0, '0, '0);
  endtask

  task automatic load_seq(int n, bit rnd);
    logic [1:0] b;
    tick(0, 1, 0, 2'd0, 0, 0, 0, 2'd0, '0, '0);
    for (int i = 0; i < n; i++) begin
      b = rnd ? 2'($urandom_range(3)) : acgt[i % 4];
      tick(0, 0, 1, b, (i == n - 1), 0, 0, 2'd0, '0, '0);
    end
  endtask

  task automatic traffic(int n, int rd_pct, int wr_pct);
    for (int i = 0; i < n; i++)
      tick(0, 0, 0, 2'd0, 0, ($urandom_range(99) < rd_pct), ($urandom_range(99) < wr_pct),
           2'($urandom_range(3)), VEF_BIT'($urandom), VEF_BIT'($urandom));
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT outputs with the oldest pending expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("o_valid", 32'(o_valid), 32'(e.valid));
        chk("o_ready", 32'(o_ready), 32'(e.ready));
        chk("o_len", 32'(o_len), 32'(e.len));
        chk("o_err", 32'(o_err), 32'(e.err));
        chk("o_t_last", 32'(o_t_last), 32'(e.last));
        if (e.valid || e.chk0) begin
          chk("o_t", 32'(o_t), 32'(e.t));
          chk("o_v", 32'(o_v), 32'(e.v));
          chk("o_f", 32'(o_f), 32'(e.f));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] t;
    m_reset();
    rst_pulse();
    idle(2);
    load_seq(4, 0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      t = m_q[0].t;
      tick(0, 0, 0, 2'd0, 0, 1, 1, t, 16'd5, 16'd7);
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 2'd0, 0, 1, 0, 2'd0, '0, '0);
    idle(1);
    tick(0, 0, 0, 2'd0, 0, 1, 0, 2'd0, '0, '0);
    idle(1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 2'd0, 0, 0, 1, 2'(i), 16'(i + 9), 16'(i + 3));
    tick(0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 16'hdead, 16'hbeef);
    tick(0, 0, 0, 2'd0, 0, 1, 1, 2'd2, 16'h1234, 16'h5678);
    idle(1);
    traffic(300, 50, 50);
    clear();
    idle(1);
    load_seq(DEPTH + 2, 1);
    traffic(200, 50, 50);
    clear();
    tick(0, 0, 0, 2'd0, 0, 1, 1, 2'd0, '0, '0);
    load_seq(5, 1);
    traffic(200, 60, 40);
    for (int k = 0; k < 3; k++) begin
      clear();
      load_seq($urandom_range(1, DEPTH), 1);
      traffic(150, 50, 50);
    end
    clear();
    load_seq(3, 1);
    traffic(20, 50, 50);
    rst_pulse();
    idle(1);
    load_seq(1, 1);
    idle(1);
    traffic(50, 50, 50);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
